// File: rtl/io_led_switch_responder_pkg.sv
// Shared constants and helpers for the LED/switch IO responder.
// Block bases, register offsets and pin widths live here so the CPU-side decode can reuse them.
package io_led_switch_responder_pkg;

  localparam logic [31:0] LED_BASE_DEFAULT = 32'hFFFF_FC60;
  localparam logic [31:0] SW_BASE_DEFAULT  = 32'hFFFF_FC70;

  localparam int unsigned LED_W = 24;
  localparam int unsigned SW_W  = 24;

  typedef enum logic [3:0] {
    OFF_LO   = 4'h0,
    OFF_HI   = 4'h2,
    OFF_STAT = 4'h4
  } io_off_e;

  // Blocks are 16-byte aligned, so only address[31:4] takes part in the hit test.
  function automatic logic block_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/io_led_switch_responder_switch_debouncer.sv
// Two-flop synchroniser plus a shared-counter debouncer for a bus of board switches.
// accept_o pulses in the cycle whose rising edge loads the new value into deb_o.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 24,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sw_async_i,
  output logic [WIDTH-1:0] deb_o,
  output logic             accept_o
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 20'd1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

  // One counter for the whole bus: further bit changes while counting do not restart it.
  always_comb begin
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d  = s2_q;
      cnt_d  = '0;
      accept = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= '0;
      s2_q  <= '0;
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= sw_async_i;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o    = deb_q;
  assign accept_o = accept;

endmodule

// File: rtl/io_led_switch_responder.sv
// Memory-mapped IO responder: LED output register, debounced switch inputs with a sticky
// change flag, and the 16-bit read word returned to the CPU-side IO mux.
module io_led_switch_responder
  import io_led_switch_responder_pkg::*;
#(
  parameter logic [31:0] LED_BASE        = LED_BASE_DEFAULT,
  parameter logic [31:0] SW_BASE         = SW_BASE_DEFAULT,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            led_cs,
  input  logic            switch_cs,
  input  logic [31:0]     address,
  input  logic [31:0]     write_data,
  input  logic [SW_W-1:0] switch_i,
  output logic [LED_W-1:0] led_o,
  output logic [15:0]     ioread_data
);

  logic [LED_W-1:0] led_q, led_d;
  logic             changed_q, changed_d;
  logic [SW_W-1:0]  deb;
  logic             accept;
  logic             led_hit, sw_hit, stat_rd;
  logic [3:0]       off;
  logic             unused_wdata;

  assign off          = address[3:0];
  assign led_hit      = block_hit(address, LED_BASE);
  assign sw_hit       = block_hit(address, SW_BASE);
  assign stat_rd      = switch_cs && sw_hit && (off == OFF_STAT);
  assign unused_wdata = ^write_data[31:16];

  switch_debouncer #(
    .WIDTH           (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_i      (clock),
    .rst_i      (reset),
    .sw_async_i (switch_i),
    .deb_o      (deb),
    .accept_o   (accept)
  );

  always_comb begin
    led_d = led_q;
    if (led_cs && led_hit) begin
      case (off)
        OFF_LO:  led_d[15:0]  = write_data[15:0];
        OFF_HI:  led_d[23:16] = write_data[7:0];
        default: led_d        = led_q;
      endcase
    end
  end

  // A fresh acceptance outranks the read-to-clear so no change event is ever lost.
  always_comb begin
    changed_d = changed_q;
    if (accept)       changed_d = 1'b1;
    else if (stat_rd) changed_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    ioread_data = '0;
    if (switch_cs && sw_hit) begin
      case (off)
        OFF_LO:   ioread_data = deb[15:0];
        OFF_HI:   ioread_data = {8'h00, deb[23:16]};
        OFF_STAT: ioread_data = {15'b0, changed_q};
        default:  ioread_data = '0;
      endcase
    end
  end

  assign led_o = led_q;

endmodule
